// File: rtl/gate_test_seq.sv
// Two-input gate tester: walks {a,b} through 00..11, holds each vector
// SETTLE_CYCLES clocks, then compares x against the expected truth table.
module gate_test_seq #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] truth,
  output logic       a,
  output logic       b,
  input  logic       x,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_n;
  logic [1:0] idx;
  logic [1:0] idx_n;
  logic [7:0] cnt;
  logic [7:0] cnt_n;
  logic [3:0] truth_q;
  logic [3:0] truth_q_n;
  logic [3:0] mask_n;
  logic [3:0] mask_upd;
  logic       a_n;
  logic       b_n;
  logic       pass_n;
  logic       settled;
  logic       miss;

  assign settled = (cnt == LAST);
  assign miss    = (x != truth_q[idx]);
  assign busy    = (state == RUN);
  assign done    = (state == DONE);

  // Mask including the sample taken at this edge
  always_comb begin
    mask_upd      = fail_mask;
    mask_upd[idx] = miss;
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    truth_q_n = truth_q;
    a_n       = a;
    b_n       = b;
    pass_n    = pass;
    mask_n    = fail_mask;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n   = RUN;
          truth_q_n = truth;
          idx_n     = 2'd0;
          cnt_n     = 8'd0;
          a_n       = 1'b0;
          b_n       = 1'b0;
          mask_n    = 4'd0;
          pass_n    = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          // Abort wins over any sample due at this edge
          state_n = IDLE;
          idx_n   = 2'd0;
          cnt_n   = 8'd0;
          a_n     = 1'b0;
          b_n     = 1'b0;
          pass_n  = 1'b0;
        end else if (!settled) begin
          cnt_n = cnt + 8'd1;
        end else begin
          mask_n = mask_upd;
          cnt_n  = 8'd0;
          if (idx != 2'd3) begin
            idx_n      = idx + 2'd1;
            {a_n, b_n} = idx + 2'd1;
          end else begin
            state_n = DONE;
            idx_n   = 2'd0;
            a_n     = 1'b0;
            b_n     = 1'b0;
            pass_n  = (mask_upd == 4'd0);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= 8'd0;
      truth_q   <= 4'd0;
      a         <= 1'b0;
      b         <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 4'd0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      truth_q   <= truth_q_n;
      a         <= a_n;
      b         <= b_n;
      pass      <= pass_n;
      fail_mask <= mask_n;
    end
  end

endmodule

// File: tb/tb_gate_test_seq.sv
// Bench for gate_test_seq: two instances (settle 4 and settle 1) driving
// behavioural gate models, with a result scoreboard popped on done.
module tb_gate_test_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4;
  logic       start1;
  logic       abort;
  logic [3:0] truth;
  logic [1:0] mode;
  logic       use1;

  logic       a4, b4, x4, busy4, done4, pass4;
  logic [3:0] fm4;
  logic       a1, b1, x1, busy1, done1, pass1;
  logic [3:0] fm1;

  logic       o_a, o_b, o_busy, o_done, o_pass;
  logic [3:0] o_fm;

  typedef struct packed {
    logic       p;
    logic [3:0] m;
  } res_t;

  res_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  function automatic logic gate(input logic [1:0] md,
                                input logic ga, input logic gb);
    case (md)
      2'd0:    return ga & gb;
      2'd1:    return ga | gb;
      default: return 1'b1;
    endcase
  endfunction

  assign x4 = gate(mode, a4, b4);
  assign x1 = gate(mode, a1, b1);

  assign o_a    = use1 ? a1 : a4;
  assign o_b    = use1 ? b1 : b4;
  assign o_busy = use1 ? busy1 : busy4;
  assign o_done = use1 ? done1 : done4;
  assign o_pass = use1 ? pass1 : pass4;
  assign o_fm   = use1 ? fm1 : fm4;

  gate_test_seq #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort),
    .truth(truth), .a(a4), .b(b4), .x(x4), .busy(busy4),
    .done(done4), .pass(pass4), .fail_mask(fm4)
  );

  gate_test_seq #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort),
    .truth(truth), .a(a1), .b(b1), .x(x1), .busy(busy1),
    .done(done1), .pass(pass1), .fail_mask(fm1)
  );

  task automatic test_reset();
    logic [8:0] got4;
    logic [8:0] got1;
    rst    = 1'b1;
    start4 = 1'b1;
    start1 = 1'b1;
    abort  = 1'b0;
    truth  = 4'b1000;
    mode   = 2'd0;
    use1   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got4 = {a4, b4, busy4, done4, pass4, fm4};
    got1 = {a1, b1, busy1, done1, pass1, fm1};
    checks++;
    if (got4 !== 9'd0) begin
      failures++;
      $display("FAIL reset_dut4 got=%b exp=%b", got4, 9'd0);
    end
    checks++;
    if (got1 !== 9'd0) begin
      failures++;
      $display("FAIL reset_dut1 got=%b exp=%b", got1, 9'd0);
    end
    @(posedge clk);
    #1;
    rst    = 1'b0;
    start4 = 1'b0;
    start1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy4, busy1} !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle busy=%b exp=00", {busy4, busy1});
    end
  endtask

  // One run: optional mid-run start injection, abort or reset edge
  task automatic run_case(input bit s1, input logic [1:0] md,
                          input logic [3:0] tv, input int inj,
                          input int ab_at, input int rst_at,
                          input string nm);
    int         s;
    int         cut;
    int         dcnt;
    bit         full;
    res_t       e;
    res_t       got;
    res_t       exp_q;
    logic [1:0] iv;
    logic [1:0] eab;
    logic       eb;
    s    = s1 ? 1 : 4;
    cut  = 4 * s;
    dcnt = 0;
    if (ab_at >= 0) cut = ab_at;
    if (rst_at >= 0) cut = rst_at;
    full = (cut == 4 * s);
    use1  = s1;
    mode  = md;
    truth = tv;
    for (int i = 0; i < 4; i++) begin
      iv     = 2'(i);
      e.m[i] = gate(md, iv[1], iv[0]) != tv[i];
    end
    e.p = (e.m == 4'd0);
    if (full) sb.push_back(e);
    @(posedge clk);
    #1;
    if (s1) start1 = 1'b1;
    else start4 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
    truth  = ~tv;
    for (int n = 0; n < 4 * s + 4; n++) begin
      @(negedge clk);
      eb  = (n < cut);
      eab = eb ? 2'(n / s) : 2'b00;
      checks++;
      if ({o_a, o_b} !== eab) begin
        failures++;
        $display("FAIL %s ab n=%0d got=%b exp=%b",
                 nm, n, {o_a, o_b}, eab);
      end
      checks++;
      if (o_busy !== eb) begin
        failures++;
        $display("FAIL %s busy n=%0d got=%b exp=%b",
                 nm, n, o_busy, eb);
      end
      if (o_done === 1'b1) begin
        dcnt++;
        checks++;
        if (n != 4 * s || sb.size() == 0) begin
          failures++;
          $display("FAIL %s done n=%0d got=1 exp=0", nm, n);
        end else begin
          exp_q = sb.pop_front();
          got.p = o_pass;
          got.m = o_fm;
          if (got !== exp_q) begin
            failures++;
            $display("FAIL %s result got=%b exp=%b",
                     nm, got, exp_q);
          end
        end
      end
      if (full && n == 4 * s + 3) begin
        checks++;
        if ({o_pass, o_fm} !== {e.p, e.m}) begin
          failures++;
          $display("FAIL %s held got=%b exp=%b",
                   nm, {o_pass, o_fm}, {e.p, e.m});
        end
      end
      if (!full && n >= cut) begin
        checks++;
        if (o_pass !== 1'b0) begin
          failures++;
          $display("FAIL %s pass_cut n=%0d got=%b exp=0",
                   nm, n, o_pass);
        end
        if (rst_at >= 0) begin
          checks++;
          if (o_fm !== 4'd0) begin
            failures++;
            $display("FAIL %s mask_rst n=%0d got=%b exp=0000",
                     nm, n, o_fm);
          end
        end
      end
      @(posedge clk);
      #1;
      start4 = !s1 && (n + 2 == inj);
      abort  = (n + 2 == ab_at);
      rst    = (n + 2 == rst_at);
    end
    checks++;
    if (dcnt != (full ? 1 : 0)) begin
      failures++;
      $display("FAIL %s done_count got=%0d exp=%0d",
               nm, dcnt, full ? 1 : 0);
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout pending=%0d exp=0", nm, sb.size());
      sb.delete();
    end
    start4 = 1'b0;
    abort  = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic test_and_pass();
    run_case(1'b0, 2'd0, 4'b1000, -1, -1, -1, "and_pass");
  endtask

  task automatic test_or_fault();
    run_case(1'b0, 2'd1, 4'b1000, -1, -1, -1, "or_fault");
  endtask

  task automatic test_stuck1_restart();
    run_case(1'b0, 2'd2, 4'b1000, 5, -1, -1, "stuck1");
  endtask

  task automatic test_abort();
    run_case(1'b0, 2'd0, 4'b1000, -1, 6, -1, "abort");
    run_case(1'b0, 2'd0, 4'b1000, -1, -1, -1, "after_abort");
  endtask

  task automatic test_midrun_reset();
    run_case(1'b0, 2'd0, 4'b1000, -1, -1, 9, "mid_reset");
    run_case(1'b0, 2'd1, 4'b1001, -1, -1, -1, "after_reset");
  endtask

  task automatic test_settle1();
    run_case(1'b1, 2'd0, 4'b1000, -1, -1, -1, "settle1_and");
    run_case(1'b1, 2'd2, 4'b1110, -1, -1, -1, "settle1_stuck");
  endtask

  task automatic test_back_to_back();
    run_case(1'b0, 2'd0, 4'b0110, -1, -1, -1, "b2b_0");
    run_case(1'b0, 2'd1, 4'b1110, -1, -1, -1, "b2b_1");
  endtask

  initial begin
    test_reset();
    test_and_pass();
    test_or_fault();
    test_stuck1_restart();
    test_abort();
    test_midrun_reset();
    test_settle1();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_test_seq.md
GATE_TEST_SEQ -- requirements
Module: gate_test_seq

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4: clock cycles each input vector is held before x is sampled (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1: request a test run, sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1: cancel a run in progress.
REQ-006 The block SHALL have port truth, input, 4: expected x per vector index i={a,b}; bit i is the expected output for that index.
REQ-007 The block SHALL have port a, output, 1: gate-under-test input a, registered.
REQ-008 The block SHALL have port b, output, 1: gate-under-test input b, registered.
REQ-009 The block SHALL have port x, input, 1: gate-under-test output.
REQ-010 The block SHALL have port busy, output, 1: high while in RUN.
REQ-011 The block SHALL have port done, output, 1: one-cycle pulse at completion.
REQ-012 The block SHALL have port pass, output, 1: high when the last completed run had no mismatches; held until the next accepted start.
REQ-013 The block SHALL have port fail_mask, output, 4: bit i set when x mismatched truth[i]; held until the next accepted start.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE, plus internal registers idx (2 bit), cnt (8 bit) and truth_q (4 bit).
REQ-015 In IDLE, start=1 at an edge SHALL go to RUN, with truth_q<=truth, idx<=0, cnt<=0, {a,b}<=2'b00, fail_mask<=0, pass<=0 and busy<=1.
REQ-016 Vector order SHALL be idx 0,1,2,3, driving {a,b} = 00, 01, 10, 11 (a=idx[1], b=idx[0]).
REQ-017 In RUN with cnt<SETTLE_CYCLES-1, the block SHALL set cnt<=cnt+1 with a/b unchanged.
REQ-018 In RUN with cnt==SETTLE_CYCLES-1, the block SHALL sample x at that edge and set fail_mask[idx] <= (x != truth_q[idx]).
REQ-019 When idx<3 at that sample edge, the block SHALL set idx<=idx+1, cnt<=0 and {a,b}<=idx+1.
REQ-020 When idx==3 at that sample edge, the block SHALL go to DONE and set busy<=0, {a,b}<=00, and pass<=1 only if no mismatch was recorded (including the final sample).
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-022 With start accepted at edge E0, x SHALL be sampled at edges E0+k*SETTLE_CYCLES for k=1..4, and done SHALL be high in the cycle after E0+4*SETTLE_CYCLES.
REQ-023 start while busy or in DONE SHALL be ignored with no effect.
REQ-024 truth changes after the accepting edge SHALL have no effect on the run.
REQ-025 abort=1 in RUN SHALL return to IDLE at that edge with {a,b}<=00, busy<=0, no done pulse, and pass=0; any x sample due at that edge is discarded.
REQ-026 abort outside RUN SHALL be ignored.
REQ-027 If abort and the final sample fall on the same edge, abort SHALL win.
REQ-028 With SETTLE_CYCLES=1, each vector SHALL be sampled at the first edge after it is driven.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE with a=0, b=0, busy=0, done=0, pass=0, fail_mask=0, idx=0, cnt=0 and truth_q=0, overriding start and abort.
REQ-030 rst asserted mid-RUN SHALL abandon the run with no done pulse; start is honoured again from the first edge with rst=0.

Verification
REQ-031 Pass case: SETTLE_CYCLES=4, x=a&b model, truth=4'b1000, start pulsed at E0 -> a/b steps 00,01,10,11 every 4 cycles; done high one cycle after E0+16; pass=1, fail_mask=0000.
REQ-032 OR-gate fault: x=a|b model, truth=4'b1000 -> pass=0, fail_mask=4'b0110.
REQ-033 Stuck-at-1 fault: x tied to 1, truth=4'b1000 -> fail_mask=4'b0111; start pulsed during RUN does not restart the run and done occurs once.
REQ-034 Abort: abort=1 at E0+6 -> busy=0 and a=b=0 from E0+6; no done pulse; pass=0; a new start is accepted afterwards and completes normally.
REQ-035 Reset: rst=1 at E0+9 mid-run -> all outputs zero next cycle with no done pulse; with SETTLE_CYCLES=1 and the AND model, done is high in the cycle after E0+4 and pass=1.
